core_alu_wb: RTL and testbench
==============================

# core_alu_wb

Execute-to-writeback stage directly downstream of the core ALU. Each cycle the ALU is started, it captures the ALU result together with the operands and decoded destination and computes NZCV flags. It queues the result in a 2-entry buffer and presents it to the register-file write port with a valid/ready handshake. It also exposes a pending-destination mask so the issue logic can stall on read-after-write hazards, and it holds the architectural flags register.

## Interface
- `W`, 16, datapath width (matches the ALU)
- `R`, 4, register index width (2^R architectural registers)
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `dec`  in  `insn_decode`  decoded instruction; uses `dec.alu.op`, `dec.wb.en`, `dec.wb.rd`, `dec.wb.set_flags`
- `start`  in  1  ALU issues an op this cycle (same signal the ALU sees)
- `a`, `b`  in  W  ALU operands
- `q`  in  W  ALU result for the current `dec`/`a`/`b`
- `flush`  in  1  discard all queued, un-retired results
- `in_ready`  out  1  buffer can accept; issue must not assert `start` while low
- `wb_valid`  out  1  head entry valid
- `wb_ready`  in  1  register file consumes head this cycle
- `wb_en`  out  1  head writes a register
- `wb_rd`  out  R  head destination
- `wb_data`  out  W  head result
- `wb_flags`  out  4  head flags {N,Z,C,V}
- `flags`  out  4  architectural flags {N,Z,C,V}
- `busy_mask`  out  2^R  bit i set while any queued entry has `wb_en` and `wb_rd`==i

## Operation
- Flag calculation is combinational from `dec.alu.op`, `a`, `b`, `q`:
  - N = q[W-1]; Z = (q == 0).
  - ADD: C = carry-out of a (W+1)-bit a+b; V = (a[W-1]==b[W-1]) && (q[W-1]!=a[W-1]).
  - SUB: C = no-borrow (a >= b unsigned); V = (a[W-1]!=b[W-1]) && (q[W-1]!=a[W-1]).
  - AND/ORR/XOR/SHL/SHR: C = 0, V = 0.
- Accept: `start && in_ready`.
  - An accepted op with `wb.en`=0 and `set_flags`=0 is a no-op and is not enqueued.
  - Otherwise the op is pushed as {wb_en, rd, q, flags, set_flags}.
- Buffer: 2-entry in-order FIFO (count 0..2).
  - `in_ready` = (count != 2), driven from registered state only.
  - Push and pop in the same cycle are allowed at count 1; count is unchanged.
  - At count 2 no push can occur.
- Pop: `wb_valid && wb_ready`. If the popped entry has `set_flags`, `flags` ← entry flags on that edge.
- Flush: synchronous. Count ← 0 and `busy_mask` ← 0 on the next edge.
  - `flags` is unchanged, except that a pop in the same cycle still retires and may update it.
  - A `start` in the same cycle as `flush` is dropped.
- `start` while `in_ready`=0 is a protocol violation; it is caught by an assertion and the op is ignored.
- `busy_mask` is the OR of decoded `rd` over valid entries with `wb_en`. Two entries with the same `rd` keep the bit set until both retire.

## Timing
- Reset (async): count 0, `wb_valid` 0, `wb_en` 0, `wb_rd` 0, `wb_data` 0, `wb_flags` 0, `flags` 0, `busy_mask` 0, `in_ready` 1. Reset asserted mid-stream discards all entries immediately.
- Latency: an op accepted on edge t appears on `wb_*` after edge t (`wb_valid` high in cycle t+1) when the buffer was empty.
- Throughput: 1 op/cycle while `wb_ready` is held high.
- `wb_*` outputs are stable while `wb_valid && !wb_ready`.
- `busy_mask` reflects a push on the same edge as the push. It does not include the op currently being offered on `start`; issue compares that op itself.

## Structure
- `core/uarch.sv` holds:
  - the `wb` sub-struct of `insn_decode` (`en`, `rd[R-1:0]`, `set_flags`);
  - `` `FLAG_N/Z/C/V `` bit-index constants;
  - the ALU op encodings already used.
- Sub-module `core_alu_flags` (combinational: op, a, b, q → {N,Z,C,V}), reused later by compare/branch logic.
- FIFO storage, pointers, mask and flags register are inline in `core_alu_wb`.

## Test plan
- ADD a=16'hFFFF b=16'h0001 q=0, rd=3, en=1, set_flags=1, wb_ready=1:
  - next cycle `wb_valid`=1, `wb_data`=0, `wb_flags`=4'b0110, `busy_mask`=16'h0008;
  - after the pop, `flags`=4'b0110 and `busy_mask`=0.
- SUB 16'h8000−16'h0001 (q=16'h7FFF) → `wb_flags`=4'b0011. SUB 5−7 (q=16'hFFFE) → `wb_flags`=4'b1000.
- `wb_ready`=0, three back-to-back starts to rd 1,2,2:
  - `in_ready` falls after the second accept;
  - `busy_mask`=16'h0006;
  - after release, results retire in order and the third op is accepted once count<2.
- Count 2, `flush`=1 with `start`=1 the same cycle → next cycle count 0, `wb_valid`=0, `busy_mask`=0, `flags` unchanged, started op lost.
- `start` with en=0, set_flags=0 → `in_ready` stays 1, `wb_valid` stays 0, `flags` unchanged.
- `rst_n` low asynchronously while `wb_valid`=1 → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/core_alu_wb_pkg.sv
// Shared decode types, flag bit positions and ALU op encodings for the
// execute/writeback slice.
package core_alu_wb_pkg;

    localparam int REG_IDX_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
    } alu_ctl_t;

    typedef struct packed {
        logic                 en;
        logic [REG_IDX_W-1:0] rd;
        logic                 set_flags;
    } wb_ctl_t;

    typedef struct packed {
        alu_ctl_t alu;
        wb_ctl_t  wb;
    } insn_decode;

endpackage

// File: rtl/core_alu_wb_flags.sv
// Combinational NZCV generation from ALU op, operands and result; shared with
// compare/branch logic.
module core_alu_flags
    import core_alu_wb_pkg::*;
#(
    parameter int W = 16
) (
    input  alu_op_e        op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [W-1:0]   q_i,
    output logic [3:0]     flags_o
);

    logic [W-1:0] sum_w;

    always_comb begin
        sum_w   = a_i + b_i;
        flags_o = '0;
        flags_o[FLAG_N] = q_i[W-1];
        flags_o[FLAG_Z] = (q_i == '0);
        case (op_i)
            ALU_ADD: begin
                // A wrapped W-bit sum is smaller than either operand exactly on carry-out.
                flags_o[FLAG_C] = (sum_w < a_i);
                flags_o[FLAG_V] = (a_i[W-1] == b_i[W-1]) && (q_i[W-1] != a_i[W-1]);
            end
            ALU_SUB: begin
                flags_o[FLAG_C] = (a_i >= b_i);
                flags_o[FLAG_V] = (a_i[W-1] != b_i[W-1]) && (q_i[W-1] != a_i[W-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/core_alu_wb.sv
// Execute-to-writeback stage: 2-entry result queue with register-file handshake,
// pending-destination mask and architectural NZCV register.
module core_alu_wb
    import core_alu_wb_pkg::*;
#(
    parameter int W = 16,
    parameter int R = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  insn_decode      dec,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    q,
    input  logic            flush,
    output logic            in_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_en,
    output logic [R-1:0]    wb_rd,
    output logic [W-1:0]    wb_data,
    output logic [3:0]      wb_flags,
    output logic [3:0]      flags,
    output logic [2**R-1:0] busy_mask
);

    typedef struct packed {
        logic         en;
        logic [R-1:0] rd;
        logic [W-1:0] data;
        logic [3:0]   flags;
        logic         set_flags;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     new_ent;
    entry_t     head;
    logic [1:0] vld_q, vld_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] alu_flags;
    logic       push;
    logic       pop;

    core_alu_flags #(.W(W)) u_flags (
        .op_i    (dec.alu.op),
        .a_i     (a),
        .b_i     (b),
        .q_i     (q),
        .flags_o (alu_flags)
    );

    assign new_ent = '{en: dec.wb.en, rd: dec.wb.rd[R-1:0], data: q,
                       flags: alu_flags, set_flags: dec.wb.set_flags};

    assign head     = ent_q[rd_ptr_q];
    assign in_ready = ~&vld_q;
    assign wb_valid = vld_q[rd_ptr_q];
    assign push     = start && in_ready && !flush && (dec.wb.en || dec.wb.set_flags);
    assign pop      = wb_valid && wb_ready;

    // Storage is unreset; every consumer below qualifies it with a valid bit.
    assign wb_en    = wb_valid && head.en;
    assign wb_rd    = wb_valid ? head.rd    : '0;
    assign wb_data  = wb_valid ? head.data  : '0;
    assign wb_flags = wb_valid ? head.flags : '0;
    assign flags    = flags_q;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ~rd_ptr_q;
            if (head.set_flags) flags_d = head.flags;
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (flush) begin
            vld_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ent_q[wr_ptr_q] <= new_ent;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (vld_q[i] && ent_q[i].en) busy_mask[ent_q[i].rd] = 1'b1;
        end
    end

    // A start coinciding with flush is discarded anyway, so it is not a violation.
    a_no_start_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(start && !in_ready && !flush));

endmodule

// File: tb/tb_core_alu_wb.sv
// Directed self-checking bench for core_alu_wb.
module tb_core_alu_wb;
    import core_alu_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    insn_decode  dec;
    logic        start, flush, wb_ready;
    logic [15:0] a, b, q;
    logic        in_ready, wb_valid, wb_en;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  wb_flags, flags;
    logic [15:0] busy_mask;

    int checks = 0;
    int errors = 0;

    core_alu_wb #(.W(16), .R(4)) dut (
        .clk(clk), .rst_n(rst_n), .dec(dec), .start(start), .a(a), .b(b), .q(q),
        .flush(flush), .in_ready(in_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
        .flags(flags), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] qv, input logic en, input logic [3:0] rd,
                         input logic sf, input logic st);
        dec.alu.op = op; dec.wb.en = en; dec.wb.rd = rd; dec.wb.set_flags = sf;
        a = av; b = bv; q = qv; start = st;
    endtask

    task automatic test_reset;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags); end
        checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
        checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
    endtask

    task automatic test_add;
        wb_ready = 1'b1;
        drive(ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_data !== 16'h0000) begin errors++; $display("FAIL add_wb_data: got %h expected 0000", wb_data); end
        checks++; if (wb_flags !== 4'b0110) begin errors++; $display("FAIL add_wb_flags: got %b expected 0110", wb_flags); end
        checks++; if (busy_mask !== 16'h0008) begin errors++; $display("FAIL add_busy: got %h expected 0008", busy_mask); end
        checks++; if (wb_rd !== 4'd3 || wb_en !== 1'b1) begin errors++; $display("FAIL add_rd_en: got rd=%0d en=%b expected rd=3 en=1", wb_rd, wb_en); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL add_flags_early: got %b expected 0000", flags); end
        tick;
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL add_flags_retired: got %b expected 0110", flags); end
        checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL add_busy_clear: got %h expected 0000", busy_mask); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %b expected 0", wb_valid); end
    endtask

    task automatic test_sub;
        wb_ready = 1'b1;
        drive(ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 4'd5, 1'b1, 1'b1);
        tick;
        checks++; if (wb_flags !== 4'b0011) begin errors++; $display("FAIL sub_ovf_flags: got %b expected 0011", wb_flags); end
        checks++; if (busy_mask !== 16'h0020) begin errors++; $display("FAIL sub_busy: got %h expected 0020", busy_mask); end
        drive(ALU_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 4'd5, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (wb_flags !== 4'b1000 || wb_data !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow: got flags=%b data=%h expected 1000 fffe", wb_flags, wb_data); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL sub_flags_first: got %b expected 0011", flags); end
        tick;
        checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL sub_flags_second: got %b expected 1000", flags); end
    endtask

    task automatic test_logic;
        wb_ready = 1'b1;
        drive(ALU_SHL, 16'h8000, 16'h0001, 16'h0000, 1'b1, 4'd7, 1'b0, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (wb_flags !== 4'b0100) begin errors++; $display("FAIL shl_flags: got %b expected 0100", wb_flags); end
        tick;
        checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL shl_no_set_flags: got %b expected 1000", flags); end
    endtask

    task automatic test_back_to_back;
        wb_ready = 1'b0;
        drive(ALU_ORR, 16'h0010, 16'h0001, 16'h0011, 1'b1, 4'd1, 1'b0, 1'b1);
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one: got %b expected 1", in_ready); end
        drive(ALU_ORR, 16'h0020, 16'h0002, 16'h0022, 1'b1, 4'd2, 1'b0, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", in_ready); end
        checks++; if (busy_mask !== 16'h0006) begin errors++; $display("FAIL b2b_busy: got %h expected 0006", busy_mask); end
        tick;
        checks++; if (wb_data !== 16'h0011 || wb_rd !== 4'd1) begin errors++; $display("FAIL b2b_stable: got data=%h rd=%0d expected 0011 rd=1", wb_data, wb_rd); end
        wb_ready = 1'b1;
        tick;
        checks++; if (wb_data !== 16'h0022 || wb_rd !== 4'd2) begin errors++; $display("FAIL b2b_order2: got data=%h rd=%0d expected 0022 rd=2", wb_data, wb_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
        checks++; if (busy_mask !== 16'h0004) begin errors++; $display("FAIL b2b_busy_one: got %h expected 0004", busy_mask); end
        drive(ALU_ORR, 16'h0030, 16'h0003, 16'h0033, 1'b1, 4'd2, 1'b0, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (wb_data !== 16'h0033 || wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_order3: got data=%h valid=%b expected 0033 1", wb_data, wb_valid); end
        checks++; if (busy_mask !== 16'h0004) begin errors++; $display("FAIL b2b_busy_same_rd: got %h expected 0004", busy_mask); end
        tick;
        checks++; if (wb_valid !== 1'b0 || busy_mask !== 16'h0) begin errors++; $display("FAIL b2b_drained: got valid=%b busy=%h expected 0 0000", wb_valid, busy_mask); end
    endtask

    task automatic test_flush;
        wb_ready = 1'b0;
        drive(ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 4'd4, 1'b1, 1'b1);
        tick;
        drive(ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 4'd6, 1'b1, 1'b1);
        tick;
        checks++; if (busy_mask !== 16'h0050 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill: got busy=%h ready=%b expected 0050 0", busy_mask, in_ready); end
        drive(ALU_SUB, 16'h0009, 16'h0001, 16'h0008, 1'b1, 4'd9, 1'b1, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        start = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", wb_valid); end
        checks++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL flush_busy: got %h expected 0000", busy_mask); end
        checks++; if (flags !== 4'b1000 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_flags: got flags=%b ready=%b expected 1000 1", flags, in_ready); end
        tick;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_start_lost: got %b expected 0", wb_valid); end
        drive(ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 4'd4, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        wb_ready = 1'b1;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++; if (flags !== 4'b1001 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_with_pop: got flags=%b valid=%b expected 1001 0", flags, wb_valid); end
    endtask

    task automatic test_noop;
        wb_ready = 1'b1;
        drive(ALU_SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 4'd8, 1'b0, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL noop_ready: got %b expected 1", in_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL noop_valid: got %b expected 0", wb_valid); end
        checks++; if (flags !== 4'b1001 || busy_mask !== 16'h0) begin errors++; $display("FAIL noop_state: got flags=%b busy=%h expected 1001 0000", flags, busy_mask); end
    endtask

    task automatic test_async_reset;
        wb_ready = 1'b0;
        drive(ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b1, 4'd2, 1'b1, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", wb_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || wb_en !== 1'b0 || wb_rd !== 4'd0) begin errors++; $display("FAIL areset_wb: got valid=%b en=%b rd=%0d expected 0 0 0", wb_valid, wb_en, wb_rd); end
        checks++; if (wb_data !== 16'h0 || wb_flags !== 4'h0) begin errors++; $display("FAIL areset_data: got data=%h flags=%b expected 0000 0000", wb_data, wb_flags); end
        checks++; if (flags !== 4'h0 || busy_mask !== 16'h0) begin errors++; $display("FAIL areset_state: got flags=%b busy=%h expected 0000 0000", flags, busy_mask); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
        #1 rst_n = 1'b1;
        tick;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL areset_discard: got %b expected 0", wb_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        wb_ready = 1'b0;
        drive(ALU_ADD, 16'h0, 16'h0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        tick;
        test_reset;
        rst_n = 1'b1;
        tick;
        test_add;
        test_sub;
        test_logic;
        test_back_to_back;
        test_flush;
        test_noop;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
